ss_wbm_arb: RTL and testbench
=============================

SS_WBM_ARB -- requirements
Module: ss_wbm_arb

Interface
REQ-001 SHALL have parameter TMO, default 255, meaning the number of stalled strobe cycles before a forced bus error (range 1..255).
REQ-002 SHALL have parameter PARK, default 1, meaning the number of idle cycles inserted between the release of one grant and the next grant (range 0..1).
REQ-003 SHALL have port wb_clk_i, input, 1 bit: the single clock; all logic is rising-edge on it.
REQ-004 SHALL have port wb_rst_i, input, 1 bit: reset, asynchronous assert, active-low (0 = reset).
REQ-005 SHALL have ports req_cyc_i, req_stb_i, req_we_i and req_cab_i, each input, 3 bits, where bit n is requester n's Wishbone cycle, strobe, write and burst signal.
REQ-006 SHALL have port req_adr_i, input, 96 bits: requester n address in bits [32n+31:32n].
REQ-007 SHALL have port req_sel_i, input, 12 bits: requester n byte select in bits [4n+3:4n].
REQ-008 SHALL have port req_dat_i, input, 96 bits: requester n write data in bits [32n+31:32n].
REQ-009 SHALL have ports req_ack_o, req_err_o and req_rty_o, each output, 3 bits: the per-requester termination signals.
REQ-010 SHALL have port req_dat_o, output, 32 bits: read data broadcast to all requesters.
REQ-011 SHALL have ports wbm_cyc_o, wbm_stb_o, wbm_we_o and wbm_cab_o (output, 1 bit each), wbm_adr_o (output, 32 bits), wbm_sel_o (output, 4 bits) and wbm_dat_o (output, 32 bits): the shared master bus.
REQ-012 SHALL have ports wbm_ack_i, wbm_err_i and wbm_rty_i (input, 1 bit each) and wbm_dat_i (input, 32 bits): the shared master bus responses.
REQ-013 SHALL have port grant_o, output, 3 bits: one-hot current owner, 0 when idle.
REQ-014 SHALL have port tmo_o, output, 1 bit: a one-cycle pulse when a timeout fires.

Function
REQ-015 SHALL implement the states IDLE, OWN and PARK.
REQ-016 In IDLE with any req_cyc_i bit set, the block SHALL register a grant on the next edge and enter OWN, so the first wbm_cyc_o is one cycle after the request.
REQ-017 Grant selection SHALL be round-robin starting from (last_owner+1) mod 3; last_owner SHALL reset to 2, so requester 0 wins first.
REQ-018 In OWN, the wbm_* outputs SHALL combinationally mirror the granted requester's cyc/stb/we/cab/adr/sel/dat.
REQ-019 In OWN, wbm_ack_i, wbm_err_i and wbm_rty_i SHALL route only to the granted bit of req_ack_o, req_err_o and req_rty_o; the other requesters SHALL see 0.
REQ-020 Ungranted requesters SHALL be held off with no termination signals; their cyc SHALL remain pending.
REQ-021 A grant SHALL hold while the owner's cyc=1, regardless of stb gaps or cab, so bursts are never split.
REQ-022 When the owner drops cyc, the block SHALL go OWN->PARK if PARK=1, otherwise OWN->IDLE.
REQ-023 PARK SHALL last one cycle, drive all wbm_* outputs to 0, then go to IDLE.
REQ-024 With PARK=0 and another request pending, the block SHALL pass through IDLE for one cycle, giving a minimum of one dead cycle between owners.
REQ-025 The timeout counter (8 bits) SHALL clear on any ack, err or rty, on stb=0, and outside OWN.
REQ-026 The timeout counter SHALL increment each OWN cycle with owner stb=1 and no termination signal.
REQ-027 When the timeout counter equals TMO, the block SHALL, for one cycle, assert req_err_o[owner], pulse tmo_o, and force wbm_stb_o=0; the counter SHALL then clear.
REQ-028 A wbm_ack_i/err_i/rty_i arriving in the same cycle as a timeout SHALL take precedence: it is passed through, no timeout fires, and the counter clears.
REQ-029 wbm_rty_i SHALL be passed to the owner without releasing the grant; the requester decides whether to retry.
REQ-030 A requester that drops cyc in the cycle it is granted SHALL give an OWN cycle with wbm_cyc_o=0, then release per REQ-022.
REQ-031 Outside OWN, wbm_cyc_o and wbm_stb_o SHALL be 0; wbm_adr_o, wbm_sel_o and wbm_dat_o SHALL be 0; grant_o SHALL be 0.
REQ-032 req_dat_o SHALL equal wbm_dat_i at all times.

Reset
REQ-033 While wb_rst_i=0, the block SHALL force state IDLE, grant_o=0, last_owner=2, timeout counter=0, tmo_o=0, all req_*_o=0 and all wbm_* control outputs=0, immediately and without waiting for a clock edge.
REQ-034 Reset asserted mid-burst SHALL drop wbm_cyc_o asynchronously; after release, arbitration SHALL restart with requester 0 having priority.

Verification
REQ-035 Bench SHALL cover: all three req_cyc_i rise together with single accesses -> grants 0,1,2 in order, each separated by one PARK cycle.
REQ-036 Bench SHALL cover: requester 1 runs an 8-beat cab burst while requester 0 requests at beat 3 -> all 8 acks go to requester 1 with no interleave; requester 0 is granted after PARK.
REQ-037 Bench SHALL cover: owner stb held with the slave silent, TMO=16 -> req_err_o[owner] and tmo_o pulse on the 17th stalled cycle and wbm_stb_o=0 that cycle.
REQ-038 Bench SHALL cover: ack arriving exactly on the TMO cycle -> ack delivered, no err, no tmo_o.
REQ-039 Bench SHALL cover: wbm_rty_i answers requester 2 twice and then acks -> requester 2 keeps the grant throughout and grant_o stays 3'b100.
REQ-040 Bench SHALL cover: wb_rst_i pulsed low mid-burst -> wbm_cyc_o=0 before the next clock edge; after release, requester 0 wins the first grant.

Source files
------------

// File: rtl/ss_wbm_arb.sv
// Three-requester Wishbone master arbiter: round-robin grant that is held for the
// whole cycle, optional park cycle between owners, and a stalled-strobe timeout.
module ss_wbm_arb #(
    parameter int TMO  = 255,
    parameter int PARK = 1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [2:0]  req_cyc_i,
    input  logic [2:0]  req_stb_i,
    input  logic [2:0]  req_we_i,
    input  logic [2:0]  req_cab_i,
    input  logic [95:0] req_adr_i,
    input  logic [11:0] req_sel_i,
    input  logic [95:0] req_dat_i,
    output logic [2:0]  req_ack_o,
    output logic [2:0]  req_err_o,
    output logic [2:0]  req_rty_o,
    output logic [31:0] req_dat_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic        wbm_cab_o,
    output logic [31:0] wbm_adr_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic        wbm_rty_i,
    input  logic [31:0] wbm_dat_i,
    output logic [2:0]  grant_o,
    output logic        tmo_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN  = 2'd1,
        S_PARK = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] last_q,  last_d;
    logic [7:0] tcnt_q,  tcnt_d;

    logic [1:0] pick, cand;
    logic       own, own_cyc, own_stb, term, fire;

    // Walk from lowest to highest priority so the highest-priority hit wins.
    always_comb begin
        pick = 2'd0;
        cand = 2'd0;
        for (int k = 3; k >= 1; k--) begin
            cand = 2'((int'(last_q) + k) % 3);
            if (req_cyc_i[cand]) pick = cand;
        end
    end

    assign own     = (state_q == S_OWN);
    assign own_cyc = req_cyc_i[owner_q];
    assign own_stb = req_stb_i[owner_q];
    assign term    = wbm_ack_i | wbm_err_i | wbm_rty_i;
    // A real slave response in the same cycle always beats the timeout.
    assign fire    = own & own_cyc & own_stb & ~term & (tcnt_q == 8'(TMO));

    assign req_dat_o = wbm_dat_i;
    assign tmo_o     = fire;

    always_comb begin
        wbm_cyc_o = 1'b0;
        wbm_stb_o = 1'b0;
        wbm_we_o  = 1'b0;
        wbm_cab_o = 1'b0;
        wbm_adr_o = '0;
        wbm_sel_o = '0;
        wbm_dat_o = '0;
        req_ack_o = '0;
        req_err_o = '0;
        req_rty_o = '0;
        grant_o   = '0;
        if (own) begin
            wbm_cyc_o          = own_cyc;
            wbm_stb_o          = own_stb & ~fire;
            wbm_we_o           = req_we_i[owner_q];
            wbm_cab_o          = req_cab_i[owner_q];
            wbm_adr_o          = req_adr_i[32*owner_q +: 32];
            wbm_sel_o          = req_sel_i[4*owner_q +: 4];
            wbm_dat_o          = req_dat_i[32*owner_q +: 32];
            req_ack_o[owner_q] = wbm_ack_i;
            req_err_o[owner_q] = wbm_err_i | fire;
            req_rty_o[owner_q] = wbm_rty_i;
            grant_o[owner_q]   = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        tcnt_d  = '0;
        case (state_q)
            S_IDLE: begin
                if (|req_cyc_i) begin
                    state_d = S_OWN;
                    owner_d = pick;
                    last_d  = pick;
                end
            end
            S_OWN: begin
                if (!own_cyc)
                    state_d = (PARK != 0) ? S_PARK : S_IDLE;
                else if (own_stb && !term && !fire)
                    tcnt_d = tcnt_q + 8'd1;
            end
            S_PARK:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q <= S_IDLE;
            owner_q <= 2'd0;
            last_q  <= 2'd2;
            tcnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            tcnt_q  <= tcnt_d;
        end
    end

endmodule

// File: tb/tb_ss_wbm_arb.sv
// Bench for ss_wbm_arb: a parked and an unparked instance share stimulus and are
// both compared every cycle against a cycle-level reference model, plus directed cases.
module tb_ss_wbm_arb;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  cyc = '0, stb = '0, we = '0, cab = '0;
    logic [95:0] adr = '0, wdat = '0;
    logic [11:0] sel = '0;
    logic        ack = 1'b0, err = 1'b0, rty = 1'b0;
    logic [31:0] rdat = '0;

    logic [1:0][2:0]  r_ack, r_err, r_rty, gnt;
    logic [1:0][31:0] r_dat, m_adr, m_dat;
    logic [1:0]       m_cyc, m_stb, m_we, m_cab, tmo;
    logic [1:0][3:0]  m_sel;

    always #5 clk = ~clk;

    ss_wbm_arb #(.TMO(TMO), .PARK(1)) u_park (
        .wb_clk_i(clk), .wb_rst_i(rst_n),
        .req_cyc_i(cyc), .req_stb_i(stb), .req_we_i(we), .req_cab_i(cab),
        .req_adr_i(adr), .req_sel_i(sel), .req_dat_i(wdat),
        .req_ack_o(r_ack[0]), .req_err_o(r_err[0]), .req_rty_o(r_rty[0]), .req_dat_o(r_dat[0]),
        .wbm_cyc_o(m_cyc[0]), .wbm_stb_o(m_stb[0]), .wbm_we_o(m_we[0]), .wbm_cab_o(m_cab[0]),
        .wbm_adr_o(m_adr[0]), .wbm_sel_o(m_sel[0]), .wbm_dat_o(m_dat[0]),
        .wbm_ack_i(ack), .wbm_err_i(err), .wbm_rty_i(rty), .wbm_dat_i(rdat),
        .grant_o(gnt[0]), .tmo_o(tmo[0])
    );

    ss_wbm_arb #(.TMO(TMO), .PARK(0)) u_nopark (
        .wb_clk_i(clk), .wb_rst_i(rst_n),
        .req_cyc_i(cyc), .req_stb_i(stb), .req_we_i(we), .req_cab_i(cab),
        .req_adr_i(adr), .req_sel_i(sel), .req_dat_i(wdat),
        .req_ack_o(r_ack[1]), .req_err_o(r_err[1]), .req_rty_o(r_rty[1]), .req_dat_o(r_dat[1]),
        .wbm_cyc_o(m_cyc[1]), .wbm_stb_o(m_stb[1]), .wbm_we_o(m_we[1]), .wbm_cab_o(m_cab[1]),
        .wbm_adr_o(m_adr[1]), .wbm_sel_o(m_sel[1]), .wbm_dat_o(m_dat[1]),
        .wbm_ack_i(ack), .wbm_err_i(err), .wbm_rty_i(rty), .wbm_dat_i(rdat),
        .grant_o(gnt[1]), .tmo_o(tmo[1])
    );

    int checks = 0;
    int errors = 0;

    // Reference model per instance: owner (-1 = none), pending dead cycle, last owner, stall count.
    int mo[2], mp[2], ml[2], mc[2];

    // Parked-instance outputs captured at the last check point.
    logic [2:0] gq, cap_ack, cap_err, cap_rty;
    logic       cap_tmo, cap_stb, cap_cyc;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            mo[p] = -1; mp[p] = 0; ml[p] = 2; mc[p] = 0;
        end
    endtask

    task automatic model_step(input int p);
        int         o;
        logic       f, trm, found;
        logic [2:0] e_gnt, e_ack, e_err, e_rty;
        logic [3:0] e_ctl, e_sel;
        logic [31:0] e_adr, e_dat;
        trm = ack | err | rty;
        f = 1'b0; e_gnt = '0; e_ack = '0; e_err = '0; e_rty = '0;
        e_ctl = '0; e_sel = '0; e_adr = '0; e_dat = '0;
        o = mo[p];
        if (o >= 0) begin
            f     = cyc[o] && stb[o] && !trm && (mc[p] == TMO);
            e_gnt = 3'b001 << o;
            e_ctl = {cyc[o], stb[o] & ~f, we[o], cab[o]};
            e_adr = adr[32*o +: 32];
            e_sel = sel[4*o +: 4];
            e_dat = wdat[32*o +: 32];
            e_ack = 3'(ack) << o;
            e_err = 3'(err | f) << o;
            e_rty = 3'(rty) << o;
        end
        chk($sformatf("grant%0d", p), 128'(gnt[p]), 128'(e_gnt));
        chk($sformatf("ctl%0d", p), 128'({m_cyc[p], m_stb[p], m_we[p], m_cab[p]}), 128'(e_ctl));
        chk($sformatf("bus%0d", p), 128'({m_adr[p], m_sel[p], m_dat[p]}), 128'({e_adr, e_sel, e_dat}));
        chk($sformatf("term%0d", p), 128'({r_ack[p], r_err[p], r_rty[p]}), 128'({e_ack, e_err, e_rty}));
        chk($sformatf("tmo%0d", p), 128'(tmo[p]), 128'(f));
        chk($sformatf("rdat%0d", p), 128'(r_dat[p]), 128'(rdat));
        if (o >= 0) begin
            if (!cyc[o]) begin
                mo[p] = -1; mp[p] = (p == 0) ? 1 : 0; mc[p] = 0;
            end else if (stb[o] && !trm && !f) mc[p]++;
            else mc[p] = 0;
        end else if (mp[p] != 0) begin
            mp[p] = 0;
        end else begin
            found = 1'b0;
            for (int k = 1; k <= 3; k++) begin
                if (!found && cyc[(ml[p] + k) % 3]) begin
                    found = 1'b1; mo[p] = (ml[p] + k) % 3; ml[p] = mo[p];
                end
            end
        end
    endtask

    task automatic sample_step();
        model_step(0);
        model_step(1);
        gq = gnt[0]; cap_ack = r_ack[0]; cap_err = r_err[0]; cap_rty = r_rty[0];
        cap_tmo = tmo[0]; cap_stb = m_stb[0]; cap_cyc = m_cyc[0];
    endtask

    task automatic cycle();
        @(negedge clk);
        sample_step();
        @(posedge clk);
        #1;
    endtask

    // Release reset on a falling edge, check idle outputs, then align to posedge+1.
    task automatic release_rst();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        sample_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input logic [2:0] g, input int budget, input string tag);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (gq !== g && n < budget);
        chk(tag, 128'(gq), 128'(g));
    endtask

    logic [2:0] exp35[12] = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b000, 3'b010,
                               3'b010, 3'b000, 3'b000, 3'b100, 3'b100, 3'b000};

    initial begin
        #2_000_000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int beats, early0, last1, first0, k, qleft, r;
        logic done0;
        adr  = {$urandom, $urandom, $urandom};
        wdat = {$urandom, $urandom, $urandom};
        sel  = 12'($urandom);
        we   = 3'($urandom);
        model_reset();
        #12;
        chk("rst_grant", 128'(gnt), 128'(0));
        chk("rst_cyc", 128'({m_cyc, m_stb}), 128'(0));
        chk("rst_term", 128'({r_ack, r_err, r_rty, tmo}), 128'(0));
        release_rst();

        // All three request together with single accesses.
        cyc = 3'b111; stb = 3'b111;
        for (int n = 0; n < 12; n++) begin
            #1 ack = m_stb[0];
            cycle();
            chk($sformatf("rr_seq%0d", n), 128'(gq), 128'(exp35[n]));
            for (int i = 0; i < 3; i++) if (cap_ack[i]) begin cyc[i] = 1'b0; stb[i] = 1'b0; end
        end

        // Requester 1 burst of 8 with requester 0 arriving at beat 3.
        cyc[1] = 1'b1; stb[1] = 1'b1; cab[1] = 1'b1;
        beats = 0; early0 = 0; last1 = -1; first0 = -1; done0 = 1'b0;
        for (int n = 0; n < 40 && !done0; n++) begin
            #1 ack = m_stb[0];
            cycle();
            if (cap_ack[0] && beats < 8) early0++;
            if (cap_ack[1]) beats++;
            if (gq == 3'b010) last1 = n;
            if (gq == 3'b001 && first0 < 0) first0 = n;
            if (beats == 3 && !cyc[0]) begin cyc[0] = 1'b1; stb[0] = 1'b1; end
            if (beats == 8) begin cyc[1] = 1'b0; stb[1] = 1'b0; cab[1] = 1'b0; end
            if (cap_ack[0]) begin cyc[0] = 1'b0; stb[0] = 1'b0; done0 = 1'b1; end
        end
        ack = 1'b0;
        chk("burst_beats", 128'(beats), 128'(8));
        chk("burst_interleave", 128'(early0), 128'(0));
        chk("burst_r0_done", 128'(done0), 128'(1));
        chk("burst_gap", 128'(first0 - last1 - 1), 128'(2));
        cycle(); cycle(); cycle();

        // Requester 2 stalls against a silent slave.
        cyc[2] = 1'b1; stb[2] = 1'b1;
        k = 0;
        for (int n = 0; n < 40 && k < 17; n++) begin
            cycle();
            if (gq == 3'b100) begin
                k++;
                chk($sformatf("tmo_pulse%0d", k), 128'({cap_tmo, cap_err, cap_stb}),
                    128'((k == 17) ? {1'b1, 3'b100, 1'b0} : {1'b0, 3'b000, 1'b1}));
            end
        end
        chk("tmo_reached", 128'(k), 128'(17));
        for (int n = 0; n < 16; n++) cycle();
        ack = 1'b1;
        cycle();
        chk("tmo_ack_wins", 128'({cap_ack, cap_err, cap_tmo}), 128'({3'b100, 3'b000, 1'b0}));
        ack = 1'b0;
        cycle();
        chk("tmo_cleared", 128'({cap_err, cap_tmo}), 128'(0));
        cyc[2] = 1'b0; stb[2] = 1'b0;
        cycle(); cycle(); cycle();

        // Two retries then an ack: grant never moves.
        cyc[2] = 1'b1; stb[2] = 1'b1;
        wait_gnt(3'b100, 6, "rty_grant");
        rty = 1'b1;
        cycle();
        chk("rty1", 128'({gq, cap_rty}), 128'({3'b100, 3'b100}));
        cycle();
        chk("rty2", 128'({gq, cap_rty}), 128'({3'b100, 3'b100}));
        rty = 1'b0; ack = 1'b1;
        cycle();
        chk("rty_ack", 128'({gq, cap_ack}), 128'({3'b100, 3'b100}));
        ack = 1'b0; cyc[2] = 1'b0; stb[2] = 1'b0;
        cycle(); cycle(); cycle();

        // Reset asserted in the middle of a requester 1 burst.
        cyc[1] = 1'b1; stb[1] = 1'b1; cab[1] = 1'b1;
        wait_gnt(3'b010, 6, "rst_burst_grant");
        #1 ack = m_stb[0];
        cycle();
        chk("pre_rst_cyc", 128'(m_cyc[0]), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_cyc", 128'({m_cyc, gnt}), 128'(0));
        model_reset();
        ack = 1'b0; cyc = 3'b111; stb = 3'b111; cab = 3'b000;
        release_rst();
        wait_gnt(3'b001, 4, "post_rst_first");
        cyc = '0; stb = '0;
        cycle(); cycle(); cycle();

        // Randomised traffic with occasional silent windows that provoke timeouts.
        qleft = 0;
        for (int n = 0; n < 3000; n++) begin
            if (qleft > 0) qleft--;
            else if ($urandom % 48 == 0) begin qleft = 18 + int'($urandom % 12); stb = cyc; end
            if (qleft == 0) begin
                for (int i = 0; i < 3; i++) begin
                    if ($urandom % 6 == 0) cyc[i] = ~cyc[i];
                    stb[i] = cyc[i] & ($urandom % 4 != 0);
                    if ($urandom % 8 == 0) begin we[i] = 1'($urandom); cab[i] = 1'($urandom); end
                end
                r = int'($urandom % 16);
                ack = (r < 7); err = (r == 7); rty = (r == 8);
            end else begin
                ack = 1'b0; err = 1'b0; rty = 1'b0;
            end
            adr = {$urandom, $urandom, $urandom};
            wdat = {$urandom, $urandom, $urandom};
            sel = 12'($urandom);
            rdat = $urandom;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
